// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER memory stage: access sizes, LSU states
// and the store lane encoding used on the data bus.
package otter_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0]  RESULT_MEM = 2'b01;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } store_lanes_t;

  // Size encoding 2'b11 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

  function automatic store_lanes_t store_lanes(input logic [1:0] size, input logic [1:0] off,
                                               input logic [XLEN-1:0] data);
    store_lanes_t s;
    case (size)
      MEM_BYTE: begin
        s.be    = 4'b0001 << off;
        s.wdata = {4{data[7:0]}};
      end
      MEM_HALF: begin
        s.be    = off[1] ? 4'b1100 : 4'b0011;
        s.wdata = {2{data[15:0]}};
      end
      default: begin
        s.be    = 4'b1111;
        s.wdata = data;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the memory stage and the data memory.
interface mem_access_unit_if;
  import otter_mem_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_load_align.sv
// Combinational lane select and sign/zero extension of a read word.
module mem_load_align
  import otter_mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            sign,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[{off, 3'b000} +: 8];
    half_c = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: data_c = {{24{sign & byte_c[7]}}, byte_c};
      MEM_HALF: data_c = {{16{sign & half_c[15]}}, half_c};
      default:  data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one bus transaction per access, stalling the
// pipeline until it completes, with misalignment and timeout reporting.
module mem_access_unit
  import otter_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [1:0]          ResultSrcM,
  input  logic                MemWriteM,
  input  logic [XLEN-1:0]     ALUResultM,
  input  logic [XLEN-1:0]     WriteDataM,
  input  logic [1:0]          MemSizeM,
  input  logic                MemSignM,
  mem_access_unit_if.master   dbus,
  output logic                StallM,
  output logic [XLEN-1:0]     ReadDataM,
  output logic                MisalignM,
  output logic                BusErrM
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  logic [3:0]      be_q, be_d;
  logic [1:0]      off_q, off_d, size_q, size_d;
  logic            sign_q, sign_d, mis_q, mis_d, err_q, err_d;
  logic            stall_c, access_c, mis_c;
  store_lanes_t    lanes_c;
  logic [XLEN-1:0] load_c;

  assign access_c = MemWriteM | (ResultSrcM == RESULT_MEM);
  assign mis_c    = misaligned(MemSizeM, ALUResultM[1:0]);
  assign lanes_c  = store_lanes(MemSizeM, ALUResultM[1:0], WriteDataM);

  // Alignment uses the offset/size captured at request time, not the live inputs.
  mem_load_align u_align (
    .rdata  (dbus.rdata),
    .off    (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .data_c (load_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rd_d    = rd_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          stall_c = 1'b1;
          if (mis_c) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
            be_d    = lanes_c.be;
            wdata_d = lanes_c.wdata;
            off_d   = ALUResultM[1:0];
            size_d  = MemSizeM;
            sign_d  = MemSignM;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        // An ack in the expiry cycle still completes the access normally.
        if (dbus.ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rd_d = load_c;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rd_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;
  assign dbus.be    = be_q;
  // Reset forces the stall low even while the inputs still show an access.
  assign StallM     = stall_c & RST_N;
  assign ReadDataM  = rd_q;
  assign MisalignM  = mis_q;
  assign BusErrM    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner
// sequences and randomized accesses against a behavioural model.
module tb_mem_access_unit;
  import otter_mem_pkg::*;

  localparam int TO = 4;

  typedef struct {
    bit          load;
    bit          store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          sign;
    int          ack_delay;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    int          stall;
    int          req;
    bit          mis;
    bit          err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    bit          we;
  } exp_t;

  typedef struct {
    int          stall;
    int          req;
    bit          mis;
    bit          err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    bit          we;
    bit          req_in_done;
    bit          early_pulse;
    bit          unstable;
    bit          hung;
    int          ack_cyc;
    int          first_req_cyc;
  } obs_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  result_src;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic        stall;
  logic [31:0] read_data;
  logic        misalign;
  logic        bus_err;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] model_rd;

  mem_access_unit_if dbus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ResultSrcM (result_src),
    .MemWriteM  (mem_write),
    .ALUResultM (alu_result),
    .WriteDataM (write_data),
    .MemSizeM   (mem_size),
    .MemSignM   (mem_sign),
    .dbus       (dbus),
    .StallM     (stall),
    .ReadDataM  (read_data),
    .MisalignM  (misalign),
    .BusErrM    (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] rdata, input logic [1:0] size,
                                         input int off, input bit sgn);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * (off / 2))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Expected outcome of one access, given the load result held before it.
  function automatic exp_t model(input txn_t t, input logic [31:0] prev);
    exp_t e;
    int   off;
    bit   mis;
    off     = int'(t.addr[1:0]);
    e.rd    = prev;
    e.we    = t.store;
    e.addr  = t.addr - 32'(off);
    e.mis   = 1'b0;
    e.err   = 1'b0;
    if (t.size == 2'd0) begin
      e.be    = 4'(1 << off);
      e.wdata = (t.wdata & 32'hFF) * 32'h0101_0101;
    end else if (t.size == 2'd1) begin
      e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
      e.wdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e.be    = 4'hF;
      e.wdata = t.wdata;
    end
    mis = (t.size == 2'd1 && off % 2 != 0) || (t.size >= 2'd2 && off != 0);
    if (mis) begin
      e.stall = 1;
      e.req   = 0;
      e.mis   = 1'b1;
    end else if (t.ack_delay < TO) begin
      e.req   = t.ack_delay + 1;
      e.stall = t.ack_delay + 2;
      if (t.load && !t.store) e.rd = extend(t.rdata, t.size, off, t.sign);
    end else begin
      e.req   = TO;
      e.stall = TO + 1;
      e.err   = 1'b1;
      if (t.load && !t.store) e.rd = 32'h0;
    end
    return e;
  endfunction

  function automatic vec_t mk(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input bit sg, input int dly, input logic [31:0] rdat,
                              input int e_stall, input int e_req, input bit e_mis, input bit e_err,
                              input logic [31:0] e_rd, input logic [3:0] e_be, input logic [31:0] e_wd,
                              input logic [31:0] e_addr, input bit e_we);
    vec_t v;
    v.t = '{ld, st, a, wd, sz, sg, dly, rdat};
    v.e = '{e_stall, e_req, e_mis, e_err, e_rd, e_be, e_wd, e_addr, e_we};
    return v;
  endfunction

  task automatic drive(input txn_t t);
    logic [1:0] nl;
    nl = 2'($urandom_range(0, 2));
    if (nl == RESULT_MEM) nl = 2'b11;
    result_src = t.load ? RESULT_MEM : nl;
    mem_write  = t.store;
    alu_result = t.addr;
    write_data = t.wdata;
    mem_size   = t.size;
    mem_sign   = t.sign;
  endtask

  // Called and returns #1 after a rising edge; acts as the bus slave.
  task automatic do_access(input txn_t t, input bit noise, output obs_t o);
    int waits;
    bit done;
    o = '{default: 0};
    waits = 0;
    done  = 1'b0;
    drive(t);
    for (int c = 0; c < 40 && !done; c++) begin
      if (dbus.req) begin
        if (waits == 0) begin
          o.first_req_cyc = cyc;
          o.be    = dbus.be;
          o.wdata = dbus.wdata;
          o.addr  = dbus.addr;
          o.we    = dbus.we;
        end else if (dbus.be !== o.be || dbus.wdata !== o.wdata ||
                     dbus.addr !== o.addr || dbus.we !== o.we) begin
          o.unstable = 1'b1;
        end
        dbus.ack   = (waits == t.ack_delay);
        dbus.rdata = dbus.ack ? t.rdata : $urandom;
        if (dbus.ack) o.ack_cyc = cyc;
        waits++;
      end else begin
        dbus.ack   = noise;
        dbus.rdata = $urandom;
      end
      @(negedge clk);
      if (stall) begin
        o.stall++;
        if (misalign || bus_err) o.early_pulse = 1'b1;
      end else begin
        done          = 1'b1;
        o.mis         = misalign;
        o.err         = bus_err;
        o.rd          = read_data;
        o.req_in_done = dbus.req;
      end
      @(posedge clk);
      #1;
    end
    o.req  = waits;
    o.hung = !done;
  endtask

  task automatic check_obs(input string n, input exp_t e, input obs_t o);
    chk({n, ".hung"}, 32'(o.hung), 32'd0);
    chk({n, ".stall_cycles"}, 32'(o.stall), 32'(e.stall));
    chk({n, ".req_cycles"}, 32'(o.req), 32'(e.req));
    chk({n, ".misalign"}, 32'(o.mis), 32'(e.mis));
    chk({n, ".bus_err"}, 32'(o.err), 32'(e.err));
    chk({n, ".read_data"}, o.rd, e.rd);
    chk({n, ".req_in_done"}, 32'(o.req_in_done), 32'd0);
    chk({n, ".early_pulse"}, 32'(o.early_pulse), 32'd0);
    if (e.req > 0) begin
      chk({n, ".bus_unstable"}, 32'(o.unstable), 32'd0);
      chk({n, ".be"}, 32'(o.be), 32'(e.be));
      chk({n, ".wdata"}, o.wdata, e.wdata);
      chk({n, ".addr"}, o.addr, e.addr);
      chk({n, ".we"}, 32'(o.we), 32'(e.we));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      result_src = 2'($urandom_range(0, 1)) << 1;
      mem_write  = 1'b0;
      dbus.ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle.stall", 32'(stall), 32'd0);
      chk("idle.req", 32'(dbus.req), 32'd0);
      @(posedge clk);
      #1;
    end
    dbus.ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    obs_t o, o2;
    exp_t e;
    txn_t t;

    vecs[0]  = mk(0, 1, 32'h1003, 32'h0000_00A5, 2'd0, 0, 0, 32'h0,
                  2, 1, 0, 0, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h1000, 1);
    vecs[1]  = mk(1, 0, 32'h2002, 32'h0, 2'd1, 1, 3, 32'h8001_1234,
                  5, 4, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0, 32'h2000, 0);
    vecs[2]  = mk(1, 0, 32'h2002, 32'h0, 2'd1, 0, 3, 32'h8001_1234,
                  5, 4, 0, 0, 32'h0000_8001, 4'b1100, 32'h0, 32'h2000, 0);
    vecs[3]  = mk(1, 0, 32'h3001, 32'h0, 2'd2, 0, 0, 32'hFFFF_FFFF,
                  1, 0, 1, 0, 32'h0000_8001, 4'b1111, 32'h0, 32'h3000, 0);
    vecs[4]  = mk(1, 0, 32'h3000, 32'h0, 2'd2, 0, 9, 32'hFFFF_FFFF,
                  5, 4, 0, 1, 32'h0, 4'b1111, 32'h0, 32'h3000, 0);
    vecs[5]  = mk(1, 0, 32'h3004, 32'h0, 2'd2, 0, 3, 32'hDEAD_BEEF,
                  5, 4, 0, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h3004, 0);
    vecs[6]  = mk(0, 1, 32'h0012, 32'h1234_ABCD, 2'd1, 0, 2, 32'h0,
                  4, 3, 0, 0, 32'hDEAD_BEEF, 4'b1100, 32'hABCD_ABCD, 32'h0010, 1);
    vecs[7]  = mk(1, 0, 32'h0041, 32'h0, 2'd0, 1, 1, 32'h0000_8000,
                  3, 2, 0, 0, 32'hFFFF_FF80, 4'b0010, 32'h0, 32'h0040, 0);
    vecs[8]  = mk(1, 1, 32'h0050, 32'h1122_3344, 2'd2, 0, 0, 32'h5555_5555,
                  2, 1, 0, 0, 32'hFFFF_FF80, 4'b1111, 32'h1122_3344, 32'h0050, 1);
    vecs[9]  = mk(1, 0, 32'h0060, 32'h0, 2'd3, 1, 0, 32'h1234_5678,
                  2, 1, 0, 0, 32'h1234_5678, 4'b1111, 32'h0, 32'h0060, 0);
    vecs[10] = mk(0, 1, 32'h0007, 32'h0000_005A, 2'd0, 0, 7, 32'h0,
                  5, 4, 0, 1, 32'h1234_5678, 4'b1000, 32'h5A5A_5A5A, 32'h0004, 1);

    rst_n      = 1'b0;
    result_src = 2'b00;
    mem_write  = 1'b0;
    alu_result = 32'h0;
    write_data = 32'h0;
    mem_size   = 2'b00;
    mem_sign   = 1'b0;
    dbus.ack   = 1'b0;
    dbus.rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.req_we_be", {27'd0, dbus.req, dbus.we, dbus.be}, 32'd0);
    chk("reset.addr", dbus.addr, 32'h0);
    chk("reset.wdata", dbus.wdata, 32'h0);
    chk("reset.read_data", read_data, 32'h0);
    chk("reset.pulses", {30'd0, misalign, bus_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].t, 1'(i % 2), o);
      check_obs($sformatf("vec%0d", i), vecs[i].e, o);
    end
    idle(1);

    // Reset in the middle of a WAIT abandons the transaction.
    t = '{1'b1, 1'b0, 32'h0080, 32'h0, 2'd2, 1'b0, 99, 32'h0};
    drive(t);
    @(posedge clk);
    #1;
    chk("rstwait.req_before", 32'(dbus.req), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait.req", 32'(dbus.req), 32'd0);
    chk("rstwait.stall", 32'(stall), 32'd0);
    chk("rstwait.read_data", read_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = '{1'b1, 1'b0, 32'h0081, 32'h0, 2'd0, 1'b0, 0, 32'h0000_AB00};
    do_access(t, 1'b0, o);
    check_obs("after_rst", '{2, 1, 1'b0, 1'b0, 32'h0000_00AB, 4'b0010, 32'h0, 32'h0080, 1'b0}, o);
    idle(2);

    // Back-to-back store then load; stray ack during the store's DONE cycle.
    t = '{1'b0, 1'b1, 32'h0100, 32'hCAFE_F00D, 2'd2, 1'b0, 1, 32'h0};
    do_access(t, 1'b1, o);
    check_obs("b2b_store", '{3, 2, 1'b0, 1'b0, 32'h0000_00AB, 4'b1111, 32'hCAFE_F00D, 32'h0100, 1'b1}, o);
    t = '{1'b1, 1'b0, 32'h0104, 32'h0, 2'd2, 1'b0, 0, 32'h0BAD_F00D};
    do_access(t, 1'b0, o2);
    check_obs("b2b_load", '{2, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0104, 1'b0}, o2);
    // Ack cycle, DONE, IDLE of next access, then its first request cycle.
    chk("b2b.req_gap", 32'(o2.first_req_cyc - o.ack_cyc), 32'd3);
    idle(1);

    model_rd = 32'h0BAD_F00D;
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind        = int'($urandom_range(0, 2));
      t.load      = (kind != 1);
      t.store     = (kind != 0);
      t.addr      = $urandom;
      t.wdata     = $urandom;
      t.size      = 2'($urandom_range(0, 3));
      t.sign      = 1'($urandom_range(0, 1));
      t.ack_delay = int'($urandom_range(0, 5));
      t.rdata     = $urandom;
      e = model(t, model_rd);
      do_access(t, 1'($urandom_range(0, 1)), o);
      check_obs($sformatf("rnd%0d", i), e, o);
      model_rd = e.rd;
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
